// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and channel state encoding for the interrupt collector
package irq_pkg;

  localparam int DEF_NUM_SRC = 8;
  localparam int DEF_STRETCH = 4;

  localparam logic [1:0] ADDR_MASK     = 2'd0;
  localparam logic [1:0] ADDR_PENDING  = 2'd1;
  localparam logic [1:0] ADDR_OVERRUN  = 2'd2;
  localparam logic [1:0] ADDR_POLARITY = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_channel.sv
// rtl/irq_channel.sv - one interrupt source: edge detect, pulse stretcher, one-deep event queue
module irq_channel
  import irq_pkg::*;
#(
  parameter int STRETCH = DEF_STRETCH
) (
  input  logic clk,
  input  logic nreset,
  input  logic src_i,
  input  logic pol_i,
  input  logic mask_i,
  output logic event_o,
  output logic overrun_o,
  output logic cpu_int_o
);

  localparam int              CW       = $clog2(STRETCH + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(STRETCH);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  irq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          queued_q, queued_d;
  logic          prev_q, prev_d;
  logic          cpu_int_q, cpu_int_d;
  logic          ev;
  logic          ev_m;
  logic          ovr;
  logic          queued_eff;

  // Next-state logic: an event arriving while busy is remembered once; a second one is an overrun.
  always_comb begin
    prev_d     = src_i;
    ev         = pol_i ? (prev_q & ~src_i) : (src_i & ~prev_q);
    ev_m       = ev & mask_i;
    queued_eff = queued_q & mask_i;
    state_d    = state_q;
    cnt_d      = cnt_q;
    queued_d   = queued_q;
    cpu_int_d  = 1'b0;
    ovr        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ev_m) begin
          state_d   = ST_PULSE;
          cnt_d     = CNT_LOAD;
          cpu_int_d = 1'b1;
        end
      end
      ST_PULSE: begin
        if (ev_m) begin
          if (queued_q) ovr = 1'b1;
          else          queued_d = 1'b1;
        end
        if (cnt_q == CNT_ONE) begin
          state_d = ST_GAP;
        end else begin
          cnt_d     = cnt_q - CNT_ONE;
          cpu_int_d = 1'b1;
        end
      end
      ST_GAP: begin
        // An event landing in the gap itself counts as queued so it is not lost on the way to IDLE.
        if (ev_m && queued_q) ovr = 1'b1;
        if (queued_eff || ev_m) begin
          state_d   = ST_PULSE;
          cnt_d     = CNT_LOAD;
          cpu_int_d = 1'b1;
          queued_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!mask_i) queued_d = 1'b0;
  end

  // Channel state registers with asynchronous reset to idle.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      queued_q  <= 1'b0;
      prev_q    <= 1'b0;
      cpu_int_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      queued_q  <= queued_d;
      prev_q    <= prev_d;
      cpu_int_q <= cpu_int_d;
    end
  end

  assign event_o   = ev;
  assign overrun_o = ovr;
  assign cpu_int_o = cpu_int_q;

endmodule

// File: rtl/irq_collector.sv
// rtl/irq_collector.sv - interrupt collector: per-source channels plus mask/pending/overrun/polarity registers
module irq_collector
  import irq_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int STRETCH = DEF_STRETCH
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic [NUM_SRC-1:0] src_in,
  output logic [NUM_SRC-1:0] cpu_int,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_data,
  input  logic               reg_we,
  input  logic               reg_start,
  output logic [31:0]        reg_q,
  output logic               reg_done
);

  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] overrun_q, overrun_d;
  logic [NUM_SRC-1:0] polarity_q, polarity_d;
  logic [NUM_SRC-1:0] ev_vec;
  logic [NUM_SRC-1:0] ovr_vec;
  logic [NUM_SRC-1:0] wdata;
  logic [NUM_SRC-1:0] clr_pend;
  logic [NUM_SRC-1:0] clr_ovr;
  logic               reg_done_q, reg_done_d;
  logic [31:0]        rd_q, rd_d;
  logic [31:0]        rdata;
  logic               accept;
  logic               wr_en;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_ch
    irq_channel #(.STRETCH(STRETCH)) u_ch (
      .clk       (clk),
      .nreset    (nreset),
      .src_i     (src_in[g]),
      .pol_i     (polarity_q[g]),
      .mask_i    (mask_q[g]),
      .event_o   (ev_vec[g]),
      .overrun_o (ovr_vec[g]),
      .cpu_int_o (cpu_int[g])
    );
  end

  if (NUM_SRC < 32) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^reg_data[31:NUM_SRC];
  end

  // Register decode: accesses are single-cycle, a start during done is dropped, events beat W1C clears.
  always_comb begin
    accept   = reg_start & ~reg_done_q;
    wr_en    = accept & reg_we;
    wdata    = reg_data[NUM_SRC-1:0];
    rdata    = '0;
    case (reg_addr)
      ADDR_MASK:     rdata[NUM_SRC-1:0] = mask_q;
      ADDR_PENDING:  rdata[NUM_SRC-1:0] = pending_q;
      ADDR_OVERRUN:  rdata[NUM_SRC-1:0] = overrun_q;
      ADDR_POLARITY: rdata[NUM_SRC-1:0] = polarity_q;
      default:       rdata = '0;
    endcase
    clr_pend   = (wr_en && reg_addr == ADDR_PENDING) ? wdata : '0;
    clr_ovr    = (wr_en && reg_addr == ADDR_OVERRUN) ? wdata : '0;
    mask_d     = (wr_en && reg_addr == ADDR_MASK) ? wdata : mask_q;
    polarity_d = (wr_en && reg_addr == ADDR_POLARITY) ? wdata : polarity_q;
    pending_d  = (pending_q & ~clr_pend) | ev_vec;
    overrun_d  = (overrun_q & ~clr_ovr) | ovr_vec;
    reg_done_d = accept;
    rd_d       = accept ? rdata : '0;
  end

  // Register file and bus response flops; all sources enabled out of reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mask_q     <= '1;
      pending_q  <= '0;
      overrun_q  <= '0;
      polarity_q <= '0;
      reg_done_q <= 1'b0;
      rd_q       <= '0;
    end else begin
      mask_q     <= mask_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      polarity_q <= polarity_d;
      reg_done_q <= reg_done_d;
      rd_q       <= rd_d;
    end
  end

  assign reg_done = reg_done_q;
  assign reg_q    = rd_q;

endmodule

// File: tb/tb_irq_collector.sv
// tb/tb_irq_collector.sv - scoreboard bench for irq_collector with a timeline reference model
module tb_irq_collector;

  localparam int N = 8;
  localparam int S = 4;

  logic         clk       = 1'b0;
  logic         nreset    = 1'b0;
  logic [N-1:0] src_in    = '0;
  logic [N-1:0] cpu_int;
  logic [1:0]   reg_addr  = '0;
  logic [31:0]  reg_data  = '0;
  logic         reg_we    = 1'b0;
  logic         reg_start = 1'b0;
  logic [31:0]  reg_q;
  logic         reg_done;

  irq_collector #(.NUM_SRC(N), .STRETCH(S)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .src_in    (src_in),
    .cpu_int   (cpu_int),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data),
    .reg_we    (reg_we),
    .reg_start (reg_start),
    .reg_q     (reg_q),
    .reg_done  (reg_done)
  );

  always #20 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] irq;
    logic         done;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_exp_q[$];
  int          total  = 0;
  int          bad    = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  // Reference model: each source keeps the start cycle of its latest pulse and a single queued flag.
  int           m_t;
  int           m_start[N];
  bit           m_queued[N];
  logic [N-1:0] m_mask, m_pend, m_ovr, m_pol, m_prev;
  bit           m_done;
  logic [N-1:0] cur_src = '0;

  function automatic void model_reset();
    m_t = 0;
    for (int i = 0; i < N; i++) begin
      m_start[i]  = -100;
      m_queued[i] = 1'b0;
    end
    m_mask = '1; m_pend = '0; m_ovr = '0; m_pol = '0; m_prev = '0; m_done = 1'b0;
  endfunction

  task automatic step(input logic [N-1:0] src, input bit st, input bit we,
                      input logic [1:0] addr, input logic [31:0] data);
    logic [N-1:0] ev, ovr_set, clr_p, clr_o;
    logic [31:0]  rv;
    bit           acc;
    exp_t         e;
    src_in = src; reg_start = st; reg_we = we; reg_addr = addr; reg_data = data;
    acc   = st && !m_done;
    clr_p = '0;
    clr_o = '0;
    if (acc) begin
      case (addr)
        2'd0:    rv = 32'(m_mask);
        2'd1:    rv = 32'(m_pend);
        2'd2:    rv = 32'(m_ovr);
        default: rv = 32'(m_pol);
      endcase
      rd_exp_q.push_back(rv);
      if (we && addr == 2'd1) clr_p = data[N-1:0];
      if (we && addr == 2'd2) clr_o = data[N-1:0];
    end
    ovr_set = '0;
    for (int i = 0; i < N; i++) begin
      if (m_pol[i]) ev[i] = (m_prev[i] == 1'b1) && (src[i] == 1'b0);
      else          ev[i] = (m_prev[i] == 1'b0) && (src[i] == 1'b1);
      if (ev[i] && m_mask[i]) begin
        if (m_t >= m_start[i] && m_t <= m_start[i] + S) begin
          if (m_queued[i]) ovr_set[i] = 1'b1;
          else             m_queued[i] = 1'b1;
        end else begin
          m_start[i] = m_t + 1;
        end
      end
      if (!m_mask[i]) m_queued[i] = 1'b0;
    end
    m_pend = (m_pend & ~clr_p) | ev;
    m_ovr  = (m_ovr & ~clr_o) | ovr_set;
    if (acc && we && addr == 2'd0) m_mask = data[N-1:0];
    if (acc && we && addr == 2'd3) m_pol  = data[N-1:0];
    m_done = acc;
    m_prev = src;
    m_t++;
    for (int i = 0; i < N; i++) begin
      if (m_queued[i] && m_t == m_start[i] + S + 1) begin
        m_start[i]  = m_t;
        m_queued[i] = 1'b0;
      end
      e.irq[i] = (m_t >= m_start[i]) && (m_t < m_start[i] + S);
    end
    e.done = acc;
    exp_q.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic cyc(input logic [N-1:0] src, input bit st, input bit we,
                     input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    step(src, st, we, addr, data);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(cur_src, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(cur_src, 1'b1, 1'b1, a, d);
    idle(1);
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(cur_src, 1'b1, 1'b0, a, 32'd0);
    idle(1);
  endtask

  task automatic sbit(input int b, input logic v);
    cur_src[b] = v;
    cyc(cur_src, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic rst_assert();
    mon_en    = 1'b0;
    nreset    = 1'b0;
    reg_start = 1'b0;
    reg_we    = 1'b0;
    exp_q.delete();
    rd_exp_q.delete();
  endtask

  task automatic rst_release(input logic [N-1:0] s);
    @(negedge clk);
    nreset  = 1'b1;
    cur_src = s;
    model_reset();
    step(s, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  // Monitor: every cycle pops the expected interrupt/done pair; read data is popped on reg_done.
  initial begin
    exp_t        e;
    logic [31:0] rv;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en && nreset) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL exp_underflow: got no expectation for cycle at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("cpu_int", 32'(cpu_int), 32'(e.irq));
          chk("reg_done", 32'(reg_done), 32'(e.done));
        end
        if (reg_done) begin
          if (rd_exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_underflow: got reg_done with reg_q %h but no read pending at %0t", reg_q, $time);
          end else begin
            rv = rd_exp_q.pop_front();
            chk("reg_q", reg_q, rv);
          end
        end else begin
          chk("reg_q_idle", reg_q, 32'd0);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] flip;
    logic [1:0]   a;
    bit           we;
    logic [31:0]  d;

    rst_assert();
    repeat (2) @(negedge clk);
    rst_release('0);

    // single stretched pulse on source 2
    idle(9);
    sbit(2, 1'b1);
    idle(8);
    rd(2'd1);
    wr(2'd1, 32'hFF);

    // three edges two cycles apart: one queued pulse, one overrun
    sbit(0, 1'b1); sbit(0, 1'b0); sbit(0, 1'b1); sbit(0, 1'b0); sbit(0, 1'b1); sbit(0, 1'b0);
    idle(12);
    rd(2'd2);
    wr(2'd2, 32'hFF);

    // masked source still records pending
    wr(2'd0, 32'hFE);
    sbit(0, 1'b1);
    idle(8);
    rd(2'd1);
    sbit(0, 1'b0);
    wr(2'd0, 32'hFF);
    wr(2'd1, 32'hFF);

    // W1C clear colliding with an event on the same bit
    cur_src[3] = 1'b1;
    cyc(cur_src, 1'b1, 1'b1, 2'd1, 32'h08);
    idle(1);
    rd(2'd1);
    idle(6);

    // falling-edge polarity on source 4
    sbit(4, 1'b1);
    idle(8);
    wr(2'd3, 32'h10);
    idle(2);
    sbit(4, 1'b0);
    idle(8);
    sbit(4, 1'b1);
    idle(8);
    wr(2'd3, 32'h00);

    // asynchronous reset in the middle of a pulse
    sbit(1, 1'b1);
    idle(2);
    @(posedge clk);
    #7;
    rst_assert();
    #1;
    chk("rst_cpu_int", 32'(cpu_int), 32'd0);
    chk("rst_reg_done", 32'(reg_done), 32'd0);
    chk("rst_reg_q", reg_q, 32'd0);
    repeat (2) @(negedge clk);
    rst_release('0);
    rd(2'd0);
    rd(2'd1);
    idle(4);

    // random traffic, starting with whatever levels are present at reset release
    rst_assert();
    repeat (2) @(negedge clk);
    rst_release(N'($urandom));
    for (int c = 0; c < 3000; c++) begin
      flip = '0;
      for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) flip[b] = 1'b1;
      cur_src = cur_src ^ flip;
      if ($urandom_range(0, 3) == 0) begin
        a  = 2'($urandom_range(0, 3));
        we = 1'($urandom_range(0, 1));
        d  = $urandom;
        if (a == 2'd0 && $urandom_range(0, 1) == 0) d[7:0] = 8'hFF;
        cyc(cur_src, 1'b1, we, a, d);
      end else begin
        cyc(cur_src, 1'b0, 1'b0, 2'd0, 32'd0);
      end
    end
    idle(8);
    for (int r = 0; r < 4; r++) rd(2'(r));
    idle(2);
    @(posedge clk);
    #5;
    mon_en = 1'b0;
    chk("rd_left", 32'(rd_exp_q.size()), 32'd0);
    chk("exp_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
